// File: rtl/saratoga_pkg.sv
// Shared types and helpers for the saratoga load/store path: memory
// operation encoding, MEM-stage FSM states and the bus lane functions.
package saratoga_pkg;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LBU      = 4'd4,
        LHU      = 4'd5,
        SB       = 4'd6,
        SH       = 4'd7,
        SW       = 4'd8
    } lsu_op_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_RESP = 2'd2
    } mem_state_t;

    function automatic logic is_store(lsu_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Halfwords need even addresses, words need word-aligned addresses.
    function automatic logic is_misaligned(lsu_op_t op, logic [1:0] a);
        case (op)
            LH, LHU, SH: return a[0];
            LW, SW:      return a != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Loads get the same lane mask as a store of the same width.
    function automatic logic [3:0] byte_en(lsu_op_t op, logic [1:0] a);
        case (op)
            LB, LBU, SB: return 4'b0001 << a;
            LH, LHU, SH: return 4'b0011 << {a[1], 1'b0};
            default:     return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across all lanes so the byte enables pick it.
    function automatic logic [31:0] store_data(lsu_op_t op, logic [31:0] d);
        case (op)
            SB:      return {4{d[7:0]}};
            SH:      return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and
// applies sign or zero extension for sub-word loads.
module load_align
    import saratoga_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  lsu_op_t     lsu_op,
    output logic [31:0] result
);

    logic [31:0] lane;

    assign lane = rdata >> {addr_lo, 3'b000};

    // Width and signedness selection for the shifted lane.
    always_comb begin
        result = rdata;
        case (lsu_op)
            LB:      result = {{24{lane[7]}}, lane[7:0]};
            LBU:     result = {24'd0, lane[7:0]};
            LH:      result = {{16{lane[15]}}, lane[15:0]};
            LHU:     result = {16'd0, lane[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-bus transaction per memory op,
// stalls upstream until the response arrives, and produces the MEM/WB
// register set plus single-cycle trap flags.
//
// state   | meaning
// --------+---------------------------------------------------------
// MS_IDLE | no transaction outstanding; new ops accepted here
// MS_REQ  | request driven on the bus, waiting for dbus_gnt_i
// MS_RESP | request granted, waiting for dbus_rvalid_i
module mem_stage
    import saratoga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  dest_i,
    input  lsu_op_t     lsu_op_i,
    input  logic        squash,
    output logic        stall_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic        dbus_err_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        bubble_o,
    output logic [31:0] pc_o,
    output logic [31:0] result_o,
    output logic [4:0]  dest_o,
    output logic        misaligned_o,
    output logic        access_fault_o
);

    mem_state_t  state;
    lsu_op_t     op_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  dest_q;
    logic        squashed_q;

    logic        in_idle;
    logic        mem_op;
    logic        misal;
    logic        issue;
    logic        kill_resp;
    lsu_op_t     op_act;
    logic [31:0] addr_act;
    logic [31:0] wdata_act;
    logic [31:0] load_data;

    assign in_idle   = (state == MS_IDLE);
    assign mem_op    = !bubble_i && (lsu_op_i != LSU_NONE);
    assign misal     = mem_op && is_misaligned(lsu_op_i, addr_i[1:0]);
    assign issue     = in_idle && mem_op && !misal && !squash && !rst;
    // A squash landing together with rvalid still kills the result.
    assign kill_resp = squashed_q || squash;

    // In IDLE the bus is driven straight from the EX/MEM inputs so the
    // request goes out in the same cycle; afterwards the captured copy
    // keeps every bus field stable until the grant.
    assign op_act    = in_idle ? lsu_op_i : op_q;
    assign addr_act  = in_idle ? addr_i   : addr_q;
    assign wdata_act = in_idle ? wdata_i  : wdata_q;

    assign dbus_req_o   = issue || (!rst && (state == MS_REQ));
    assign dbus_we_o    = is_store(op_act);
    assign dbus_addr_o  = {addr_act[31:2], 2'b00};
    assign dbus_be_o    = byte_en(op_act, addr_act[1:0]);
    assign dbus_wdata_o = store_data(op_act, wdata_act);

    // The response cycle releases the stall so upstream advances as the
    // result is registered.
    assign stall_o = !rst && (issue || (state == MS_REQ) ||
                              ((state == MS_RESP) && !dbus_rvalid_i));

    load_align u_load_align (
        .rdata   (dbus_rdata_i),
        .addr_lo (addr_q[1:0]),
        .lsu_op  (op_q),
        .result  (load_data)
    );

    // Transaction FSM and MEM/WB register set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= MS_IDLE;
            squashed_q     <= 1'b0;
            op_q           <= LSU_NONE;
            pc_q           <= 32'd0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            dest_q         <= 5'd0;
            bubble_o       <= 1'b1;
            misaligned_o   <= 1'b0;
            access_fault_o <= 1'b0;
            pc_o           <= 32'd0;
            result_o       <= 32'd0;
            dest_o         <= 5'd0;
        end else begin
            bubble_o       <= 1'b1;
            misaligned_o   <= 1'b0;
            access_fault_o <= 1'b0;
            case (state)
                MS_IDLE: begin
                    if (!bubble_i && !squash) begin
                        if (lsu_op_i == LSU_NONE) begin
                            bubble_o <= 1'b0;
                            result_o <= addr_i;
                            pc_o     <= pc_i;
                            dest_o   <= dest_i;
                        end else if (misal) begin
                            misaligned_o <= 1'b1;
                            pc_o         <= pc_i;
                        end else begin
                            op_q       <= lsu_op_i;
                            pc_q       <= pc_i;
                            addr_q     <= addr_i;
                            wdata_q    <= wdata_i;
                            dest_q     <= dest_i;
                            squashed_q <= 1'b0;
                            state      <= dbus_gnt_i ? MS_RESP : MS_REQ;
                        end
                    end
                end
                MS_REQ: begin
                    if (squash) begin
                        squashed_q <= 1'b1;
                    end
                    if (dbus_gnt_i) begin
                        state <= MS_RESP;
                    end
                end
                MS_RESP: begin
                    if (dbus_rvalid_i) begin
                        state      <= MS_IDLE;
                        squashed_q <= 1'b0;
                        if (!kill_resp) begin
                            pc_o <= pc_q;
                            if (dbus_err_i) begin
                                access_fault_o <= 1'b1;
                            end else begin
                                bubble_o <= 1'b0;
                                dest_o   <= dest_q;
                                result_o <= is_store(op_q) ? 32'd0 : load_data;
                            end
                        end
                    end else if (squash) begin
                        squashed_q <= 1'b1;
                    end
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a cycle-indexed expectation model.
module tb_mem_stage;
    import saratoga_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        bubble_i;
    logic [31:0] pc_i, addr_i, wdata_i;
    logic [4:0]  dest_i;
    lsu_op_t     lsu_op_i;
    logic        squash;
    logic        stall_o;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
    logic [31:0] dbus_rdata_i;
    logic        bubble_o;
    logic [31:0] pc_o, result_o;
    logic [4:0]  dest_o;
    logic        misaligned_o, access_fault_o;

    mem_stage dut (
        .clk(clk), .rst(rst), .bubble_i(bubble_i), .pc_i(pc_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .dest_i(dest_i), .lsu_op_i(lsu_op_i), .squash(squash),
        .stall_o(stall_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
        .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_err_i(dbus_err_i),
        .dbus_rdata_i(dbus_rdata_i), .bubble_o(bubble_o), .pc_o(pc_o),
        .result_o(result_o), .dest_o(dest_o), .misaligned_o(misaligned_o),
        .access_fault_o(access_fault_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          bub;
        bit          mis;
        bit          af;
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  dst;
    } wb_t;

    wb_t ev [int];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  chk_en = 0;
    bit  exp_req = 0, exp_stall = 0, exp_we = 0;
    logic [31:0] exp_addr = 0, exp_wd = 0;
    logic [3:0]  exp_be = 0;
    int  stall_cnt = 0, req_cnt = 0;
    logic [3:0]  last_be = 0;
    logic [31:0] last_wd = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_is_store(lsu_op_t op);
        return op == SB || op == SH || op == SW;
    endfunction

    function automatic int m_size(lsu_op_t op);
        if (op == LH || op == LHU || op == SH) return 2;
        if (op == LW || op == SW) return 4;
        return 1;
    endfunction

    function automatic bit m_misal(lsu_op_t op, logic [31:0] a);
        return (int'(a[3:0]) % m_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(lsu_op_t op, logic [31:0] a);
        int lo;
        lo = int'(a[1:0]);
        if (m_size(op) == 1) return 4'(1 << lo);
        if (m_size(op) == 2) return (lo >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(lsu_op_t op, logic [31:0] d);
        if (op == SB) return (d % 256) * 32'h01010101;
        if (op == SH) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(lsu_op_t op, logic [31:0] a, logic [31:0] d);
        int unsigned v, b, h;
        v = d >> (8 * int'(a[1:0]));
        b = v % 256;
        h = v % 65536;
        case (op)
            LB:      return (b >= 128) ? (b + 32'hFFFFFF00) : b;
            LBU:     return b;
            LH:      return (h >= 32768) ? (h + 32'hFFFF0000) : h;
            LHU:     return h;
            default: return d;
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("stall_o", stall_o, exp_stall);
            chk1("dbus_req_o", dbus_req_o, exp_req);
            if (exp_req) begin
                chk32("dbus_addr_o", dbus_addr_o, exp_addr);
                chk1("dbus_we_o", dbus_we_o, exp_we);
                if (exp_we) begin
                    chk32("dbus_be_o", 32'(dbus_be_o), 32'(exp_be));
                    chk32("dbus_wdata_o", dbus_wdata_o, exp_wd);
                end
            end
            if (ev.exists(cyc)) begin
                chk1("bubble_o", bubble_o, ev[cyc].bub);
                chk1("misaligned_o", misaligned_o, ev[cyc].mis);
                chk1("access_fault_o", access_fault_o, ev[cyc].af);
                if (!ev[cyc].bub) begin
                    chk32("result_o", result_o, ev[cyc].res);
                    chk32("dest_o", 32'(dest_o), 32'(ev[cyc].dst));
                    chk32("pc_o", pc_o, ev[cyc].pc);
                end
            end else begin
                chk1("idle_bubble_o", bubble_o, 1'b1);
                chk1("idle_misaligned_o", misaligned_o, 1'b0);
                chk1("idle_access_fault_o", access_fault_o, 1'b0);
            end
            if (stall_o) stall_cnt++;
            if (dbus_req_o) begin
                req_cnt++;
                last_be = dbus_be_o;
                last_wd = dbus_wdata_o;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bubble_i = 1'b1; lsu_op_i = LW; addr_i = 32'h0;
        exp_req = 0; exp_stall = 0;
        repeat (n) step();
    endtask

    // gnt_dly: cycles before grant; rv_dly: cycles from grant to rvalid (>=1);
    // sq: cycle offset at which squash pulses (-1 none, 0 = in the issue cycle).
    task automatic do_op(input lsu_op_t op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [4:0] dst, input int gnt_dly,
                         input int rv_dly, input logic [31:0] rd, input bit err, input int sq);
        int  done;
        bit  sqd;
        wb_t e;
        bubble_i = 1'b0; lsu_op_i = op; addr_i = a; wdata_i = wd; pc_i = pc; dest_i = dst;
        exp_addr = a & ~32'h3;
        exp_we   = m_is_store(op);
        exp_be   = m_be(op, a);
        exp_wd   = m_wdata(op, wd);
        e.bub = 1; e.mis = 0; e.af = 0; e.pc = pc; e.res = 0; e.dst = dst;
        if (sq == 0) begin
            squash = 1'b1; exp_req = 0; exp_stall = 0;
            step();
            squash = 1'b0;
        end else if (op == LSU_NONE) begin
            exp_req = 0; exp_stall = 0;
            e.bub = 0; e.res = a;
            ev[cyc + 1] = e;
            step();
        end else if (m_misal(op, a)) begin
            exp_req = 0; exp_stall = 0;
            e.mis = 1;
            ev[cyc + 1] = e;
            step();
        end else begin
            done = gnt_dly + rv_dly;
            sqd  = (sq > 0) && (sq <= done);
            for (int i = 0; i <= done; i++) begin
                squash        = (i == sq);
                dbus_gnt_i    = (i == gnt_dly);
                dbus_rvalid_i = (i == done);
                dbus_err_i    = (i == done) && err;
                dbus_rdata_i  = (i == done) ? rd : 32'hDEADBEEF;
                exp_req       = (i <= gnt_dly);
                exp_stall     = (i != done);
                if (i == done && !sqd) begin
                    if (err) e.af = 1;
                    else begin
                        e.bub = 0;
                        e.res = m_is_store(op) ? 32'd0 : m_load(op, a, rd);
                    end
                    ev[cyc + 1] = e;
                end
                step();
            end
            dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_err_i = 0; squash = 0;
        end
        bubble_i = 1'b1; exp_req = 0; exp_stall = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bubble_i = 1'b0; lsu_op_i = LW; addr_i = 32'h10; wdata_i = 0;
        pc_i = 32'h44; dest_i = 5'd3; squash = 0;
        dbus_gnt_i = 1; dbus_rvalid_i = 0; dbus_err_i = 0; dbus_rdata_i = 0;
        repeat (3) step();
        chk1("rst_req", dbus_req_o, 1'b0);
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_bubble", bubble_o, 1'b1);
        chk1("rst_mis", misaligned_o, 1'b0);
        chk1("rst_af", access_fault_o, 1'b0);
        chk32("rst_pc", pc_o, 32'h0);
        chk32("rst_result", result_o, 32'h0);
        chk32("rst_dest", 32'(dest_o), 32'h0);
        rst = 1'b0; dbus_gnt_i = 0;
        idle(1);
        chk_en = 1;
        idle(2);

        // non-memory op
        stall_cnt = 0;
        do_op(LSU_NONE, 32'h1234, 0, 32'h100, 5'd5, 0, 1, 0, 0, -1);
        chk32("alu_result", result_o, 32'h1234);
        chk1("alu_bubble", bubble_o, 1'b0);
        chk32("alu_stall_cycles", stall_cnt, 0);
        idle(1);

        // LB, immediate grant
        stall_cnt = 0;
        do_op(LB, 32'h1003, 0, 32'h104, 5'd6, 0, 1, 32'h80FFFFFF, 0, -1);
        chk32("lb_result", result_o, 32'hFFFFFF80);
        chk1("lb_bubble", bubble_o, 1'b0);
        chk32("lb_stall_cycles", stall_cnt, 1);
        idle(1);

        // SH, grant delayed 3 cycles
        req_cnt = 0;
        do_op(SH, 32'h2002, 32'hABCD1234, 32'h108, 5'd0, 3, 1, 0, 0, -1);
        chk32("sh_req_cycles", req_cnt, 4);
        chk32("sh_be", 32'(last_be), 32'hC);
        chk32("sh_wdata", last_wd, 32'h12341234);
        chk32("sh_result", result_o, 32'h0);
        chk1("sh_bubble", bubble_o, 1'b0);
        idle(1);

        // misaligned LW
        req_cnt = 0;
        do_op(LW, 32'h3001, 0, 32'h10C, 5'd7, 0, 1, 0, 0, -1);
        chk32("mis_req_cycles", req_cnt, 0);
        chk1("mis_flag", misaligned_o, 1'b1);
        chk1("mis_bubble", bubble_o, 1'b1);
        idle(1);

        // LW squashed in RESP, rvalid two cycles later, then a 1-cycle op
        do_op(LW, 32'h4000, 0, 32'h110, 5'd8, 0, 3, 32'h11112222, 0, 1);
        chk1("sqr_bubble", bubble_o, 1'b1);
        chk1("sqr_mis", misaligned_o, 1'b0);
        chk1("sqr_af", access_fault_o, 1'b0);
        do_op(LSU_NONE, 32'h5A5A, 0, 32'h114, 5'd9, 0, 1, 0, 0, -1);
        chk1("sqr_idle_after", bubble_o, 1'b0);
        idle(1);

        // LHU with bus error
        do_op(LHU, 32'h5002, 0, 32'h118, 5'd10, 1, 1, 32'h12345678, 1, -1);
        chk1("af_flag", access_fault_o, 1'b1);
        chk1("af_bubble", bubble_o, 1'b1);
        idle(1);
        chk1("af_one_cycle", access_fault_o, 1'b0);

        // model-checked mix, several back-to-back
        do_op(LH,  32'h0002, 0, 32'h200, 5'd11, 0, 1, 32'h80010000, 0, -1);
        do_op(LBU, 32'h0001, 0, 32'h204, 5'd12, 2, 2, 32'h0000F000, 0, -1);
        do_op(LHU, 32'h0000, 0, 32'h208, 5'd13, 0, 1, 32'h12349ABC, 0, -1);
        do_op(LW,  32'h0008, 0, 32'h20C, 5'd14, 1, 1, 32'hCAFEF00D, 0, -1);
        do_op(SB,  32'h0101, 32'h00000055, 32'h210, 5'd0, 0, 1, 0, 0, -1);
        do_op(SW,  32'h0200, 32'h87654321, 32'h214, 5'd0, 1, 2, 0, 0, -1);
        do_op(LB,  32'h0003, 0, 32'h218, 5'd15, 0, 1, 32'h7F000000, 0, -1);
        do_op(SH,  32'h0001, 32'h1, 32'h21C, 5'd0, 0, 1, 0, 0, -1);
        do_op(LH,  32'h0003, 0, 32'h220, 5'd16, 0, 1, 0, 0, -1);
        do_op(SW,  32'h0002, 32'h1, 32'h224, 5'd0, 0, 1, 0, 0, -1);
        do_op(LW,  32'h0300, 0, 32'h228, 5'd17, 0, 1, 0, 0, 0);
        do_op(LW,  32'h0304, 0, 32'h22C, 5'd18, 2, 1, 32'h1, 0, 1);
        do_op(LW,  32'h0308, 0, 32'h230, 5'd19, 0, 1, 32'h2, 1, 1);
        do_op(LSU_NONE, 32'hFFFF0000, 0, 32'h234, 5'd31, 0, 1, 0, 0, -1);
        idle(2);

        // reset in the middle of a transaction; late rvalid/gnt ignored
        bubble_i = 0; lsu_op_i = LW; addr_i = 32'h6000; pc_i = 32'h300; dest_i = 5'd20;
        dbus_gnt_i = 1; exp_req = 1; exp_stall = 1; exp_addr = 32'h6000; exp_we = 0;
        step();
        dbus_gnt_i = 0; exp_req = 0; exp_stall = 1;
        step();
        chk_en = 0; rst = 1; bubble_i = 1;
        step();
        chk1("midrst_bubble", bubble_o, 1'b1);
        chk32("midrst_pc", pc_o, 32'h0);
        rst = 0; ev.delete();
        dbus_rvalid_i = 1; dbus_gnt_i = 1; dbus_rdata_i = 32'hBAD0BAD0;
        exp_req = 0; exp_stall = 0; chk_en = 1;
        step();
        dbus_rvalid_i = 0; dbus_gnt_i = 0;
        idle(1);
        chk1("late_rvalid_ignored", bubble_o, 1'b1);
        do_op(LW, 32'h0010, 0, 32'h304, 5'd21, 0, 1, 32'h0BADF00D, 0, -1);
        chk32("post_rst_lw", result_o, 32'h0BADF00D);
        idle(2);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
